// File: rtl/speed_report_collector_pkg.sv
// Shared definitions for the speed report path: default widths and the
// report word layout {crossing_id, speed}.
package speed_report_collector_pkg;

  localparam int SPEED_W_DEFAULT       = 32;
  localparam int NUM_CROSSINGS_DEFAULT = 4;

  // A report word carries the crossing index above the speed value.
  function automatic int rpt_word_w(input int id_w, input int speed_w);
    return id_w + speed_w;
  endfunction

  // Crossing index reached by stepping 'off' places upward from 'base', with wrap.
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/speed_report_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rdata whenever the FIFO is not empty. Pushes at full and pops at empty are
// ignored. Full is evaluated before any same-cycle pop.
module speed_report_fifo
  import speed_report_collector_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Zero the head when empty so the outputs read 0 after reset without resetting the array.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; it is only read when the level says the entry is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/speed_report_collector.sv
// Collects one-cycle speed pulses from every crossing, holds one pending
// report per crossing, arbitrates round-robin into a report FIFO and delivers
// {crossing_id, speed} over a valid/ready stream. Overwritten pending reports
// are flagged per crossing and counted in a saturating drop counter.
module speed_report_collector
  import speed_report_collector_pkg::*;
#(
  parameter int NUM_CROSSINGS = NUM_CROSSINGS_DEFAULT,
  parameter int SPEED_W       = SPEED_W_DEFAULT,
  parameter int FIFO_DEPTH    = 8,
  parameter int ID_W          = $clog2(NUM_CROSSINGS),
  parameter int DROP_CNT_W    = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CROSSINGS*SPEED_W-1:0] speed_val_flat,
  input  logic [NUM_CROSSINGS-1:0]         speed_valid,
  output logic                             rpt_valid,
  input  logic                             rpt_ready,
  output logic [ID_W-1:0]                  rpt_crossing_id,
  output logic [SPEED_W-1:0]               rpt_speed,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic [NUM_CROSSINGS-1:0]         overrun_flags,
  output logic [DROP_CNT_W-1:0]            drop_count
);

  localparam int WORD_W = rpt_word_w(ID_W, SPEED_W);
  localparam int SUM_W  = DROP_CNT_W + 1;

  logic [NUM_CROSSINGS-1:0] pending;
  logic [SPEED_W-1:0]       pending_val [NUM_CROSSINGS];
  logic [ID_W-1:0]          rr_ptr;
  logic [ID_W-1:0]          grant_idx;
  logic                     grant_valid;
  logic [NUM_CROSSINGS-1:0] grant_oh;
  logic [NUM_CROSSINGS-1:0] overwrite;
  logic [ID_W:0]            overwrite_cnt;
  logic [SUM_W-1:0]         drop_sum;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [WORD_W-1:0]        push_word;
  logic [WORD_W-1:0]        head_word;

  // Round-robin grant: first pending crossing at or above rr_ptr, with wrap.
  // Scanning offsets downward lets the nearest pending crossing win last.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    if (!fifo_full) begin
      for (int k = NUM_CROSSINGS - 1; k >= 0; k--) begin
        if (pending[wrap_idx(int'(rr_ptr), k, NUM_CROSSINGS)]) begin
          grant_valid = 1'b1;
          grant_idx   = ID_W'(wrap_idx(int'(rr_ptr), k, NUM_CROSSINGS));
        end
      end
    end
    if (grant_valid) grant_oh[grant_idx] = 1'b1;
  end

  // A pulse replacing a pending, ungranted report is a drop; count them this cycle.
  always_comb begin
    overwrite     = speed_valid & pending & ~grant_oh;
    overwrite_cnt = '0;
    for (int i = 0; i < NUM_CROSSINGS; i++) begin
      overwrite_cnt = overwrite_cnt + {{ID_W{1'b0}}, overwrite[i]};
    end
    drop_sum = SUM_W'(drop_count) + SUM_W'(overwrite_cnt);
  end

  // Capture: a new pulse always lands in pending; a grant without a new pulse clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      for (int i = 0; i < NUM_CROSSINGS; i++) pending_val[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CROSSINGS; i++) begin
        if (speed_valid[i]) begin
          pending[i]     <= 1'b1;
          pending_val[i] <= speed_val_flat[i*SPEED_W +: SPEED_W];
        end else if (grant_oh[i]) begin
          pending[i]     <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer moves just past the granted crossing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == ID_W'(NUM_CROSSINGS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Sticky overrun flags and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_flags <= '0;
      drop_count    <= '0;
    end else begin
      overrun_flags <= overrun_flags | overwrite;
      drop_count    <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end
  end

  assign push_word = {grant_idx, pending_val[grant_idx]};

  speed_report_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant_valid),
    .wdata (push_word),
    .pop   (rpt_ready),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign rpt_valid                    = !fifo_empty;
  assign {rpt_crossing_id, rpt_speed} = head_word;

endmodule

// File: tb/tb_speed_report_collector.sv
// Self-checking bench for speed_report_collector: directed scenarios plus
// randomized traffic, compared every cycle against a queue-based model.
module tb_speed_report_collector;

  localparam int N     = 4;
  localparam int SW    = 32;
  localparam int DEPTH = 8;
  localparam int IDW   = 2;
  localparam int DW    = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*SW-1:0] speed_val_flat;
  logic [N-1:0]    speed_valid;
  logic            rpt_valid;
  logic            rpt_ready;
  logic [IDW-1:0]  rpt_crossing_id;
  logic [SW-1:0]   rpt_speed;
  logic [3:0]      fifo_level;
  logic [N-1:0]    overrun_flags;
  logic [DW-1:0]   drop_count;

  speed_report_collector #(
    .NUM_CROSSINGS (N),
    .SPEED_W       (SW),
    .FIFO_DEPTH    (DEPTH),
    .ID_W          (IDW),
    .DROP_CNT_W    (DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .speed_val_flat  (speed_val_flat),
    .speed_valid     (speed_valid),
    .rpt_valid       (rpt_valid),
    .rpt_ready       (rpt_ready),
    .rpt_crossing_id (rpt_crossing_id),
    .rpt_speed       (rpt_speed),
    .fifo_level      (fifo_level),
    .overrun_flags   (overrun_flags),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          id;
    logic [SW-1:0] spd;
  } rpt_t;

  bit            m_pend [N];
  logic [SW-1:0] m_val  [N];
  int            m_rr;
  rpt_t          m_q [$];
  int            m_drops;
  logic [N-1:0]  m_flags;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_val[i]  = '0;
    end
    m_rr    = 0;
    m_q.delete();
    m_drops = 0;
    m_flags = '0;
  endtask

  // One clock edge: grant from pre-edge state, pop, push, then capture pulses.
  task automatic model_edge(input logic [N-1:0] v, input logic [N*SW-1:0] vals, input logic rdy);
    int   g;
    rpt_t r;
    g = -1;
    if (m_q.size() < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (g >= 0) begin
      r.id  = g;
      r.spd = m_val[g];
      m_q.push_back(r);
      m_pend[g] = 1'b0;
      m_rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (m_pend[i]) begin
          if (m_drops < 65535) m_drops++;
          m_flags[i] = 1'b1;
        end
        m_pend[i] = 1'b1;
        m_val[i]  = vals[i*SW +: SW];
      end
    end
  endtask

  task automatic compare_all();
    check("rpt_valid", 64'(rpt_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("rpt_crossing_id", 64'(rpt_crossing_id), 64'(m_q[0].id));
      check("rpt_speed", 64'(rpt_speed), 64'(m_q[0].spd));
    end
    check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    check("overrun_flags", 64'(overrun_flags), 64'(m_flags));
    check("drop_count", 64'(drop_count), 64'(m_drops));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(rpt_valid), 64'd0);
    check({tag, "_id"}, 64'(rpt_crossing_id), 64'd0);
    check({tag, "_speed"}, 64'(rpt_speed), 64'd0);
    check({tag, "_level"}, 64'(fifo_level), 64'd0);
    check({tag, "_flags"}, 64'(overrun_flags), 64'd0);
    check({tag, "_drops"}, 64'(drop_count), 64'd0);
  endtask

  function automatic logic [N*SW-1:0] pack4(input logic [SW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Drive inputs, take one edge, advance the model, compare 1 time unit later.
  task automatic step(input logic [N-1:0] v, input logic [N*SW-1:0] vals, input logic rdy, input bit cmp);
    speed_valid    = v;
    speed_val_flat = vals;
    rpt_ready      = rdy;
    @(posedge clk);
    model_edge(v, vals, rdy);
    #1;
    if (cmp) compare_all();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step('0, '0, rdy, 1'b1);
  endtask

  // Asynchronous assert (checked before any clock edge), release on a falling edge.
  task automatic do_reset(input string tag);
    speed_valid    = '0;
    speed_val_flat = '0;
    rpt_ready      = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [SW-1:0] exp_seq [9];

  initial begin
    rst_n          = 1'b1;
    speed_valid    = '0;
    speed_val_flat = '0;
    rpt_ready      = 1'b0;
    #2;
    do_reset("por");
    compare_all();

    // Single report on crossing 2.
    step(4'b0100, pack4(0, 0, 250, 0), 1'b1, 1'b1);
    check("single_lat_valid", 64'(rpt_valid), 64'd0);
    step('0, '0, 1'b1, 1'b1);
    check("single_valid", 64'(rpt_valid), 64'd1);
    check("single_id", 64'(rpt_crossing_id), 64'd2);
    check("single_speed", 64'(rpt_speed), 64'd250);
    step('0, '0, 1'b1, 1'b1);
    check("single_level", 64'(fifo_level), 64'd0);
    check("single_drops", 64'(drop_count), 64'd0);

    // Simultaneous pulses from rr_ptr=0, then 1 and 3.
    do_reset("rst2");
    step(4'b1111, pack4(10, 20, 30, 40), 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step('0, '0, 1'b1, 1'b1);
      check("simul_id", 64'(rpt_crossing_id), 64'(k));
      check("simul_speed", 64'(rpt_speed), 64'(10 * (k + 1)));
    end
    step(4'b1010, pack4(0, 11, 0, 33), 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b1);
    check("pair_first_id", 64'(rpt_crossing_id), 64'd1);
    step('0, '0, 1'b1, 1'b1);
    check("pair_second_id", 64'(rpt_crossing_id), 64'd3);
    idle(3, 1'b1);

    // Grant collision on crossing 0.
    step(4'b0001, pack4(5, 0, 0, 0), 1'b1, 1'b1);
    step(4'b0001, pack4(6, 0, 0, 0), 1'b1, 1'b1);
    check("collide_first", 64'(rpt_speed), 64'd5);
    step('0, '0, 1'b1, 1'b1);
    check("collide_second", 64'(rpt_speed), 64'd6);
    check("collide_drops", 64'(drop_count), 64'd0);
    check("collide_flags", 64'(overrun_flags), 64'd0);
    idle(3, 1'b1);

    // Back-pressure to full, then one overwrite.
    for (int v = 1; v <= 9; v++) step(4'b0010, pack4(0, SW'(v), 0, 0), 1'b0, 1'b1);
    check("full_level", 64'(fifo_level), 64'd8);
    step(4'b0010, pack4(0, 10, 0, 0), 1'b0, 1'b1);
    check("full_drops", 64'(drop_count), 64'd1);
    check("full_flag1", 64'(overrun_flags[1]), 64'd1);
    for (int i = 0; i < 8; i++) exp_seq[i] = SW'(i + 1);
    exp_seq[8] = 10;
    for (int i = 0; i < 9; i++) begin
      check("drain_valid", 64'(rpt_valid), 64'd1);
      check("drain_speed", 64'(rpt_speed), 64'(exp_seq[i]));
      step('0, '0, 1'b1, 1'b1);
      if (i == 0) check("pop_at_full_level", 64'(fifo_level), 64'd7);
    end
    check("drain_empty", 64'(rpt_valid), 64'd0);

    // Stall stability: head must not move for 20 cycles.
    step(4'b1111, pack4($urandom, $urandom, $urandom, $urandom), 1'b0, 1'b1);
    idle(20, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      step(4'($urandom) & 4'($urandom), pack4($urandom, $urandom, $urandom, $urandom),
           1'($urandom_range(0, 3) != 0), 1'b1);
    end

    // Drop counter saturation: every crossing overwrites each cycle with the FIFO full.
    for (int c = 0; c < 16400; c++) begin
      step(4'b1111, pack4($urandom, $urandom, $urandom, $urandom), 1'b0, 1'b0);
    end
    compare_all();
    step(4'b1111, pack4(1, 2, 3, 4), 1'b0, 1'b1);
    check("sat_drops", 64'(drop_count), 64'hFFFF);
    check("sat_flags", 64'(overrun_flags), 64'hF);

    // Reset with 3 queued and 2 pending.
    do_reset("rst3");
    step(4'b0111, pack4(1, 2, 3, 0), 1'b0, 1'b1);
    idle(3, 1'b0);
    step(4'b1001, pack4(7, 0, 0, 9), 1'b0, 1'b1);
    check("pre_rst_level", 64'(fifo_level), 64'd3);
    do_reset("midop");
    idle(10, 1'b1);
    check("post_rst_valid", 64'(rpt_valid), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
